// File: rtl/fsm_sched_pkg.sv
// Shared definitions for the FSM input scheduler: controller state encoding
// and the default microprogram state numbers.
package fsm_sched_pkg;

    // Encoding chosen so bit 1 is busy and bit 0 is the owner index.
    typedef enum logic [1:0] {
        CTRL_IDLE = 2'b00,
        CTRL_OWN0 = 2'b10,
        CTRL_OWN1 = 2'b11
    } ctrl_state_e;

    localparam logic [3:0] DEF_IDLE_STATE  = 4'd0;
    localparam logic [3:0] DEF_DISP1_STATE = 4'd3;
    localparam logic [3:0] DEF_DISP2_STATE = 4'd10;
    localparam logic [7:0] IDLE_CNT_MAX    = 8'hFF;

    function automatic ctrl_state_e own_state(input logic idx);
        return idx ? CTRL_OWN1 : CTRL_OWN0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fsm_input_scheduler.sv
// Shares one microprogrammed FSM between two requesters, feeding each owner's
// tokens into the FSM's dispatch states and reporting traversal completion.
module fsm_input_scheduler
    import fsm_sched_pkg::*;
#(
    parameter logic [3:0] IDLE_STATE  = DEF_IDLE_STATE,
    parameter logic [3:0] DISP1_STATE = DEF_DISP1_STATE,
    parameter logic [3:0] DISP2_STATE = DEF_DISP2_STATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_inp,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_inp,
    output logic       req1_ready,
    input  logic [3:0] fsm_state,
    output logic [1:0] fsm_inp,
    output logic       busy,
    output logic       owner,
    output logic       done0,
    output logic       done1,
    output logic       proto_err,
    output logic [7:0] idle_cnt
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic        r_last;
    logic        r_done0;
    logic        r_done1;
    logic        r_proto_err;
    logic [7:0]  r_idle_cnt;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_at_idle;
    logic        w_at_disp1;
    logic        w_at_disp2;
    logic        w_own_idx;
    logic        w_own_valid;
    logic        w_done0;
    logic        w_done1;
    logic        w_err_set;
    logic        w_idle_inc;

    assign w_req       = {req1_valid, req0_valid};
    assign w_at_idle   = (fsm_state == IDLE_STATE);
    assign w_at_disp1  = (fsm_state == DISP1_STATE);
    assign w_at_disp2  = (fsm_state == DISP2_STATE);
    assign w_own_idx   = r_state[0];
    assign w_own_valid = w_own_idx ? req1_valid : req0_valid;

    rr_arb2 u_arb (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and registered-event decisions; IDLE_STATE takes priority
    // over the dispatch states should parameters ever coincide.
    always_comb begin
        w_state_nxt = r_state;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        w_err_set   = 1'b0;
        w_idle_inc  = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (w_at_disp1) begin
                    if (w_grant != 2'b00) begin
                        w_state_nxt = own_state(w_grant[1]);
                    end else begin
                        w_idle_inc = 1'b1;
                    end
                end
            end
            CTRL_OWN0, CTRL_OWN1: begin
                if (w_at_idle) begin
                    w_state_nxt = CTRL_IDLE;
                    w_done0     = ~w_own_idx;
                    w_done1     = w_own_idx;
                end else if (w_at_disp1) begin
                    w_err_set = 1'b1;
                    if (w_grant != 2'b00) begin
                        w_state_nxt = own_state(w_grant[1]);
                    end else begin
                        w_state_nxt = CTRL_IDLE;
                        w_idle_inc  = 1'b1;
                    end
                end else if (w_at_disp2 && !w_own_valid) begin
                    w_err_set  = 1'b1;
                    w_idle_inc = 1'b1;
                end
            end
            default: w_state_nxt = CTRL_IDLE;
        endcase
    end

    always_comb begin
        fsm_inp    = 2'b00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (w_at_disp1 && (r_state == CTRL_IDLE || (r_state[1] && !w_at_idle))) begin
            req0_ready = w_grant[0];
            req1_ready = w_grant[1];
            if (w_grant[0]) begin
                fsm_inp = req0_inp;
            end else if (w_grant[1]) begin
                fsm_inp = req1_inp;
            end
        end else if (r_state[1] && !w_at_idle && w_at_disp2 && w_own_valid) begin
            req0_ready = ~w_own_idx;
            req1_ready = w_own_idx;
            fsm_inp    = w_own_idx ? req1_inp : req0_inp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_proto_err <= 1'b0;
            r_idle_cnt  <= 8'd0;
        end else begin
            if (w_done0) begin
                r_last <= 1'b0;
            end else if (w_done1) begin
                r_last <= 1'b1;
            end
            r_done0 <= w_done0;
            r_done1 <= w_done1;
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
            if (w_idle_inc && r_idle_cnt != IDLE_CNT_MAX) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end
        end
    end

    assign busy      = r_state[1];
    assign owner     = r_state[0];
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign proto_err = r_proto_err;
    assign idle_cnt  = r_idle_cnt;

endmodule
